bist_stim_capture: RTL and testbench

- Sequential self-test driver for the combinational benchmark netlists in this codebase. It is the other end of the netlist's input/output interface.
- It generates pseudo-random input vectors with an LFSR and drives them into the DUT inputs.
- It compacts the DUT outputs into a MISR signature, then compares that signature against a golden value.
- One instance wraps one netlist (default sized for a 4-input / 7-output circuit).

---
 rtl/bist_stim_capture.sv | 118 +++++++++++
 tb/tb_bist_stim_capture.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_stim_capture.sv
// Self-test driver for one combinational netlist: an LFSR drives the netlist inputs,
// a MISR compacts its outputs, and the signature is compared against a golden value.
module bist_stim_capture #(
    parameter int                IN_W      = 4,
    parameter int                OUT_W     = 7,
    parameter int                MISR_W    = 8,
    parameter logic [IN_W-1:0]   LFSR_SEED = 4'b0001,
    parameter logic [IN_W-1:0]   LFSR_TAPS = 4'b1100,
    parameter logic [MISR_W-1:0] MISR_TAPS = 8'b10111000,
    parameter int                PAT_CNT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MISR_W-1:0] golden_sig,
    output logic [IN_W-1:0]   stim,
    input  logic [OUT_W-1:0]  resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam int              CNT_W    = $clog2(PAT_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_CNT - 1);

    generate
        if (LFSR_SEED == '0 || PAT_CNT < 1 || OUT_W > MISR_W) begin : g_bad_params
            $error("bist_stim_capture: LFSR_SEED must be nonzero, PAT_CNT >= 1, OUT_W <= MISR_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CMP,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [IN_W-1:0]   lfsr_q,  lfsr_d;
    logic [MISR_W-1:0] misr_q,  misr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              done_q,  done_d;
    logic              pass_q,  pass_d;

    logic [IN_W-1:0]   lfsr_nxt;
    logic [MISR_W-1:0] misr_nxt;

    // The MISR folds in resp for the vector currently on stim, so both shifts happen together.
    assign lfsr_nxt = {lfsr_q[IN_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    assign misr_nxt = {misr_q[MISR_W-2:0], ^(misr_q & MISR_TAPS)} ^ MISR_W'(resp);

    always_comb begin
        // NOTE: every next-state signal is given its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    lfsr_d  = LFSR_SEED;
                    misr_d  = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                lfsr_d = lfsr_nxt;
                misr_d = misr_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                pass_d  = (misr_q == golden_sig);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // All outputs come straight from registers, so no input reaches an output combinationally.
    assign stim      = lfsr_q;
    assign signature = misr_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_CMP);
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_bist_stim_capture.sv
// Bench for bist_stim_capture: table-driven vector model plus cycle-by-cycle comparison
// of the default instance, and directed literal checks of a PAT_CNT=1 instance.
module tb_bist_stim_capture;

    localparam int PAT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] golden_sig = 8'h00;
    logic [3:0] stim;
    logic [6:0] resp;
    logic       busy, done, pass;
    logic [7:0] signature;
    bit         resp_zero = 1'b0;

    logic       start1 = 1'b0;
    logic [7:0] golden1 = 8'h00;
    logic [3:0] stim1;
    logic       busy1, done1, pass1;
    logic [7:0] signature1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Expected LFSR vector order for x^4+x^3+1 from seed 1.
    logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    always #5 clk = ~clk;

    // Stand-in 4-in / 7-out combinational netlist.
    function automatic logic [6:0] netlist(input logic [3:0] s);
        return {s[3] & s[2], s[1] | s[0], s[3] ^ s[1], ~s[2], s[0] & s[1] & s[2], s[3] | ~s[0], ^s};
    endfunction

    assign resp = resp_zero ? 7'h00 : netlist(stim);

    bist_stim_capture u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .golden_sig(golden_sig),
        .stim(stim), .resp(resp), .busy(busy), .done(done), .pass(pass),
        .signature(signature)
    );

    bist_stim_capture #(.PAT_CNT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .golden_sig(golden1),
        .stim(stim1), .resp(7'h01), .busy(busy1), .done(done1), .pass(pass1),
        .signature(signature1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [6:0] r);
        return {m[6:0], ^(m & 8'hB8)} ^ {1'b0, r};
    endfunction

    function automatic logic [6:0] model_resp(input int v);
        return resp_zero ? 7'h00 : netlist(seq[v % 15]);
    endfunction

    function automatic logic [7:0] run_sig(input bit zero);
        logic [7:0] m = 8'h00;
        for (int i = 0; i < PAT; i++) m = misr_step(m, zero ? 7'h00 : netlist(seq[i]));
        return m;
    endfunction

    // Model: m_t counts edges since the start edge (-1 idle, 1..PAT captures, PAT+1 done).
    int         m_t = -1;
    int         m_vec = 0;
    logic [7:0] m_sig = 8'h00;
    logic       m_done = 1'b0;
    logic       m_pass = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_t <= -1; m_vec <= 0; m_sig <= 8'h00; m_done <= 1'b0; m_pass <= 1'b0;
        end else if ((m_t < 0 || m_t > PAT) && start) begin
            m_t <= 0; m_vec <= 0; m_sig <= 8'h00; m_done <= 1'b0; m_pass <= 1'b0;
        end else if (m_t >= 0 && m_t < PAT) begin
            m_sig <= misr_step(m_sig, model_resp(m_vec));
            m_vec <= m_vec + 1;
            m_t   <= m_t + 1;
        end else if (m_t == PAT) begin
            m_pass <= (m_sig == golden_sig);
            m_done <= 1'b1;
            m_t    <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_stim", 32'(stim), 32'(seq[m_vec % 15]));
            check("cyc_busy", 32'(busy), 32'(m_t >= 0 && m_t <= PAT));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_signature", 32'(signature), 32'(m_sig));
            if (m_done) check("cyc_pass", 32'(pass), 32'(m_pass));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges are numbered with the start-sampling edge as edge 1.
    task automatic run_and_measure(input bit sel, output int busy_cycles, output int done_edge);
        if (sel) start1 = 1'b1; else start = 1'b1;
        tick();
        if (sel) start1 = 1'b0; else start = 1'b0;
        busy_cycles = 0;
        done_edge   = 0;
        for (int e = 1; e <= 40; e++) begin
            if (sel ? done1 : done) begin
                done_edge = e;
                break;
            end
            if (sel ? busy1 : busy) busy_cycles++;
            tick();
        end
        if (done_edge == 0) check("done_timeout", 32'(sel ? done1 : done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         bc, de, eps, len;
        logic [7:0] sig_full, held_sig;
        logic       held_pass;

        sig_full = run_sig(1'b0);
        check("model_zero_run", 32'(run_sig(1'b1)), 32'h00);
        check("model_step_resp1", 32'(misr_step(8'h00, 7'h01)), 32'h01);
        check("model_step_fb", 32'(misr_step(8'h80, 7'h00)), 32'h01);
        check("model_step_both", 32'(misr_step(8'h01, 7'h01)), 32'h03);

        tick();
        tick();
        chk_en = 1'b1;
        check("rst_stim", 32'(stim), 32'h1);
        check("rst_signature", 32'(signature), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_stim_p1", 32'(stim1), 32'h1);
        rst_n = 1'b1;
        tick();

        // Full run against the matching golden value.
        golden_sig = sig_full;
        run_and_measure(1'b0, bc, de);
        check("t1_busy_cycles", 32'(bc), 32'd16);
        check("t1_done_edge", 32'(de), 32'd17);
        check("t1_signature", 32'(signature), 32'(sig_full));
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_stim_wrapped", 32'(stim), 32'h1);

        // Golden off by one bit.
        golden_sig = sig_full ^ 8'h01;
        run_and_measure(1'b0, bc, de);
        check("t2_signature", 32'(signature), 32'(sig_full));
        check("t2_pass", 32'(pass), 32'd0);

        // Reset in the middle of a run, then an identical full run.
        golden_sig = sig_full;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t3_rst_stim", 32'(stim), 32'h1);
        check("t3_rst_signature", 32'(signature), 32'h00);
        check("t3_rst_busy", 32'(busy), 32'd0);
        check("t3_rst_done", 32'(done), 32'd0);
        check("t3_rst_pass", 32'(pass), 32'd0);
        run_and_measure(1'b0, bc, de);
        check("t3_done_edge", 32'(de), 32'd17);
        check("t3_signature", 32'(signature), 32'(sig_full));
        check("t3_pass", 32'(pass), 32'd1);

        // All-zero response keeps the signature at zero.
        resp_zero  = 1'b1;
        golden_sig = 8'h00;
        run_and_measure(1'b0, bc, de);
        check("t4_signature", 32'(signature), 32'h00);
        check("t4_pass", 32'(pass), 32'd1);
        resp_zero  = 1'b0;

        // start held high: back-to-back runs, each DONE lasting one cycle.
        golden_sig = sig_full;
        start = 1'b1;
        eps = 0;
        len = 0;
        for (int i = 0; i < 120 && eps < 3; i++) begin
            tick();
            if (done) begin
                len++;
                if (len == 1) check("t5_run_signature", 32'(signature), 32'(sig_full));
            end else if (len > 0) begin
                check("t5_done_len", 32'(len), 32'd1);
                eps++;
                len = 0;
            end
        end
        check("t5_runs", 32'(eps), 32'd3);
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) tick();
        check("t5_final_done", 32'(done), 32'd1);

        // DONE holds with start low, then restarts on a pulse.
        held_sig  = signature;
        held_pass = pass;
        check("t6_pass", 32'(held_pass), 32'd1);
        repeat (20) begin
            tick();
            check("t6_hold_done", 32'(done), 32'd1);
            check("t6_hold_sig", 32'(signature), 32'(held_sig));
            check("t6_hold_pass", 32'(pass), 32'(held_pass));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_restart_done", 32'(done), 32'd0);
        check("t6_restart_stim", 32'(stim), 32'h1);
        check("t6_restart_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 40 && !done; i++) tick();

        // Single-vector instance with constant response 1.
        golden1 = 8'h01;
        run_and_measure(1'b1, bc, de);
        check("p1_busy_cycles", 32'(bc), 32'd2);
        check("p1_done_edge", 32'(de), 32'd3);
        check("p1_signature", 32'(signature1), 32'h01);
        check("p1_stim", 32'(stim1), 32'h2);
        check("p1_pass", 32'(pass1), 32'd1);

        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
